// File: rtl/cswap_unadd_serial_pkg.sv
// Shared definitions for the serial un-add unit: FSM state encodings and default sizes.
package cswap_unadd_serial_pkg;

    localparam int W_DEFAULT  = 8;
    localparam int CW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cswap_unadd_serial_cell.sv
// Reversible per-bit un-add cell built only from controlled-swap gates.
//   b      = s ^ a ^ c
//   c_next = maj(a, b, c), which reduces to (s ^ c) ? c : a
// Garbage outputs land on w_unused_* nets that go nowhere.
module cswap_unadd_cell (
    input  logic a,
    input  logic s,
    input  logic c,
    output logic b,
    output logic c_next
);

    logic w_c1, w_c2, w_nc;
    logic w_t, w_t1, w_t2, w_nt;
    logic w_a1;
    logic w_unused_s, w_unused_sc, w_unused_ab, w_unused_t, w_unused_mx;

    // fan out c and produce ~c (constants 0/1 on the data inputs)
    cswap_gate u_g_c (
        .i_c(c), .i_x(1'b0), .i_y(1'b1),
        .o_c(w_c1), .o_x(w_c2), .o_y(w_nc)
    );

    // t = s ^ c : select between c and ~c under s
    cswap_gate u_g_sc (
        .i_c(s), .i_x(w_c1), .i_y(w_nc),
        .o_c(w_unused_s), .o_x(w_t), .o_y(w_unused_sc)
    );

    // fan out t and produce ~t
    cswap_gate u_g_t (
        .i_c(w_t), .i_x(1'b0), .i_y(1'b1),
        .o_c(w_t1), .o_x(w_t2), .o_y(w_nt)
    );

    // b = a ^ t ; control output carries a copy of a forward
    cswap_gate u_g_b (
        .i_c(a), .i_x(w_t1), .i_y(w_nt),
        .o_c(w_a1), .o_x(b), .o_y(w_unused_ab)
    );

    // majority as a mux: when a != b (i.e. t=1) the carry follows c, else it follows a
    cswap_gate u_g_maj (
        .i_c(w_t2), .i_x(w_a1), .i_y(w_c2),
        .o_c(w_unused_t), .o_x(c_next), .o_y(w_unused_mx)
    );

endmodule

// File: rtl/cswap_unadd_serial_gate.sv
// Controlled-swap (Fredkin) gate: control passes through; x and y swap when control is 1.
module cswap_gate (
    input  logic i_c,
    input  logic i_x,
    input  logic i_y,
    output logic o_c,
    output logic o_x,
    output logic o_y
);

    assign o_c = i_c;
    assign o_x = i_c ? i_y : i_x;
    assign o_y = i_c ? i_x : i_y;

endmodule

// File: rtl/cswap_unadd_serial.sv
// Bit-serial inverse adder: recovers B = S - A - cin (mod 2^W) one bit per cycle, LSB first,
// and flags when the recomputed final carry disagrees with the claimed carry-out.
//
//   state | meaning
//   IDLE  | ready for a request
//   RUN   | W cycles of per-bit un-add, LSB first
//   DONE  | result presented, waiting for out_ready
module cswap_unadd_serial
    import cswap_unadd_serial_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_s,
    input  logic         in_cin,
    input  logic         in_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_b,
    output logic         out_cout,
    output logic         out_err
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_s;
    logic [W-1:0]   r_b;
    logic           r_carry;
    logic           r_cexp;
    logic [W-1:0]   r_out_b;
    logic           r_out_cout;
    logic           r_out_err;

    logic           w_accept;
    logic           w_last;
    logic           w_bit;
    logic           w_carry_nxt;
    logic [W-1:0]   w_b_shift;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_b     = r_out_b;
    assign out_cout  = r_out_cout;
    assign out_err   = r_out_err;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == RUN) && (r_cnt == CW'(W - 1));
    assign w_b_shift = {w_bit, r_b[W-1:1]};

    cswap_unadd_cell u_cell (
        .a      (r_a[0]),
        .s      (r_s[0]),
        .c      (r_carry),
        .b      (w_bit),
        .c_next (w_carry_nxt)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = RUN;
            RUN:  if (w_last) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // operand shift registers, carry, counter and held result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_s        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_cexp     <= 1'b0;
            r_out_b    <= '0;
            r_out_cout <= 1'b0;
            r_out_err  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_s     <= in_s;
            r_b     <= '0;
            r_carry <= in_cin;
            r_cexp  <= in_cout;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_s     <= r_s >> 1;
            r_b     <= w_b_shift;
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + CW'(1);
            // results are captured once so they survive the next request's RUN phase
            if (w_last) begin
                r_out_b    <= w_b_shift;
                r_out_cout <= w_carry_nxt;
                r_out_err  <= w_carry_nxt ^ r_cexp;
            end
        end
    end

endmodule

// File: tb/tb_cswap_unadd_serial.sv
module tb_cswap_unadd_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_s;
    logic         in_cin;
    logic         in_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_b;
    logic         out_cout;
    logic         out_err;

    typedef struct {
        logic [W-1:0] b;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    cswap_unadd_serial #(.W(W), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_s      (in_s),
        .in_cin    (in_cin),
        .in_cout   (in_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_cout  (out_cout),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: compare every output handshake against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=out_b 0x%0h expected=no result t=%0t", out_b, $time);
            end else begin
                e = q.pop_front();
                chk("out_b", 32'(out_b), 32'(e.b));
                chk("out_cout", 32'(out_cout), 32'(e.cout));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] s, input logic ci, input logic co,
                        input logic [W-1:0] eb, input logic ecout, input logic eerr);
        int   n;
        logic acc;
        exp_t e;
        in_a = a; in_s = s; in_cin = ci; in_cout = co; in_valid = 1'b1;
        n = 0;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no accept expected=accept within 200 cycles");
        end else begin
            e.b = eb; e.cout = ecout; e.err = eerr;
            q.push_back(e);
            accept_cyc = cyc;
        end
    endtask

    initial begin
        int n;
        int first_acc;
        logic [W-1:0] ra, rb, rs;
        logic         rci, rco;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_s = '0; in_cin = 1'b0; in_cout = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_b", 32'(out_b), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic subtract and latency
        send(8'h35, 8'h7A, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 32'(n), 32'(W + 1));
        @(posedge clk); #1;

        // 2: full-width carry ripple
        send(8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        // 3: claimed carry mismatch
        send(8'h80, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1);
        // extra vector: wrap with consistent carry
        send(8'hC0, 8'h10, 1'b0, 1'b1, 8'h50, 1'b1, 1'b0);

        // 4: back-pressure
        n = 0;
        while (q.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        send(8'h10, 8'h30, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin in_a = 8'h01; in_s = 8'h01; in_valid = 1'b1; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_b", 32'(out_b), 32'h20);
            chk("bp_out_cout", 32'(out_cout), 32'd0);
            chk("bp_out_err", 32'(out_err), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_resume_in_ready", 32'(in_ready), 32'd1);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_hold_out_b", 32'(out_b), 32'h20);
        chk("bp_queue_drained", 32'(q.size()), 32'd0);

        // 5: reset mid-operation on the 4th RUN cycle
        send(8'h12, 8'h34, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_b", 32'(out_b), 32'd0);
        void'(q.pop_back());
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(8'h12, 8'h34, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);

        // 6: back-to-back random traffic against a reference adder
        first_acc = 0;
        for (int k = 0; k < 1000; k++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
            send(ra, rs, rci, rco, rb, rco, 1'b0);
            if (k == 0) first_acc = accept_cyc;
        end
        chk("throughput", 32'(accept_cyc - first_acc), 32'(999 * (W + 2)));

        n = 0;
        while (q.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cswap_unadd_serial.md
Name: cswap_unadd_serial

Overview:
- Bit-serial inverse ("un-add") unit for the team's reversible Fredkin-gate adders.
- Takes one operand A, carry-in, sum S and claimed carry-out from a forward add, and recovers the other operand B = S - A - cin (mod 2^W).
- Checks that the recomputed final carry matches the claimed carry-out.
- Processes one bit per cycle, LSB first, through a reversible per-bit cell, with valid/ready handshakes on both sides.

Parameters:
- W, 8, operand/sum width in bits (W >= 2).
- CW, 4, bit-counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit idle and able to accept a request.
- in_a  input  W  known operand A.
- in_s  input  W  sum S.
- in_cin  input  1  carry-in of the forward add.
- in_cout  input  1  claimed carry-out of the forward add.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_b  output  W  recovered operand B.
- out_cout  output  1  recomputed final carry.
- out_err  output  1  recomputed carry differs from in_cout.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - in_ready=1, out_valid=0, out_b=0, out_cout=0, out_err=0.
  - State IDLE; counter, shift registers and carry register all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a and in_s into shift registers, in_cin into the carry register and in_cout into an expected-carry register; clear the counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, with a=A[0], s=S[0], c=carry:
    - b = s^a^c.
    - next carry = maj(a,b,c).
  - b is shifted into the MSB of the B shift register; A and S shift right by one.
  - Counter increments each cycle. After the cycle with counter==W-1, go to DONE.
  - RUN lasts exactly W cycles.
- DONE:
  - out_valid=1.
  - out_b = B register. out_cout = carry register. out_err = carry != expected.
  - Outputs are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle. out_b, out_cout and out_err keep their last values.
- Latency: the accept edge, then W RUN cycles, then out_valid is asserted. Total W+1 clocks from handshake to out_valid (9 for W=8). The earliest new accept is the cycle after the output handshake.
- Busy behaviour: in_valid while not IDLE is ignored. No queuing; the producer must hold the request.
- Reset mid-operation: asynchronous return to IDLE with the reset values. The partial result is discarded and no out_valid is produced.
- Wrap-around: arithmetic is mod 2^W. When S < A+cin, the mathematically consistent result requires in_cout=1; out_err flags any inconsistency.
- Error reporting: out_err is informational only. out_b is always S-A-cin mod 2^W.
- Per-bit cell:
  - Purely combinational and reversible: uses controlled-swap gates only, with constant inputs 0/1.
  - No buffer/not primitives beyond those inside the controlled-swap gate.
  - Garbage outputs are left unconnected.

Decomposition:
- Shared include file holds:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The default width constant.
- Sub-module cswap_unadd_cell:
  - Inputs a, s, c; outputs b, c_next.
  - Built from the team's existing controlled-swap gate module.
- Top level holds the FSM, counter, shift registers and handshake logic only.

Test Plan:
1. A=0x35, S=0x7A, cin=0, cout=0 -> out_b=0x45, out_cout=0, out_err=0; out_valid rises 9 clocks after accept.
2. A=0xFF, S=0x00, cin=1, cout=1 -> out_b=0x00, out_cout=1, out_err=0 (full-width carry ripple).
3. A=0x80, S=0x00, cin=0, cout=0 -> out_b=0x80, out_cout=1, out_err=1 (claimed-carry mismatch).
4. Output back-pressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; a pulsed in_valid with A=0x01 is ignored; accept resumes the cycle after out_ready=1.
5. Reset mid-operation: assert rst on the 4th RUN cycle of A=0x12, S=0x34 -> same cycle in_ready=1, out_valid=0, out_b=0. A new request A=0x12, S=0x34, cin=0, cout=0 -> out_b=0x22, out_err=0.
6. Back-to-back: random A, B, cin; S and cout computed by the reference adder model; 1000 requests with out_ready=1 -> out_b==B, out_err==0 always; throughput one result per W+2 cycles.
